// File: rtl/ex_mul_sequencer.sv
// Iterative shift-add multiplier sequencer for EX-stage mul instructions.
// Optional early termination when the remaining multiplier bits are zero: MUL_EARLY_OUT_EN.
//
// state | meaning
// IDLE  | waiting for a mul in ID/EX; accepts when mul_req & !flush_in
// RUN   | one shift-add step per cycle, pipeline stalled
// DONE  | product registered, result_valid pulses, stall released
module ex_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_req,
    input  logic             sign_in,
    input  logic             flush_in,
    input  logic [0:WIDTH-1] opA_in,
    input  logic [0:WIDTH-1] opB_in,
    output logic             stall_out,
    output logic             busy_out,
    output logic             result_valid,
    output logic [0:WIDTH-1] result_lo_out,
    output logic [0:WIDTH-1] result_hi_out,
    output logic             ovf_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic               neg;
    logic               sgn;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic               accept;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_hi_step;
    logic [WIDTH-1:0]   mplier_step;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fin;
    logic               ovf_fin;
    logic               early_done;
    logic               last_step;

    // Ports are MSB-first ([0] = MSB); positional assignment keeps the numeric value.
    assign op_a   = opA_in;
    assign op_b   = opB_in;
    assign mag_a  = (sign_in && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign mag_b  = (sign_in && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    assign neg_in = sign_in & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);

    assign accept = reset & (state == ST_IDLE) & mul_req & ~flush_in;

    always_comb begin
        addend      = mplier[0] ? {1'b0, mcand} : '0;
        sum         = {1'b0, acc_hi} + addend;
        acc_hi_step = sum[WIDTH:1];
        mplier_step = {sum[0], mplier[WIDTH-1:1]};
        prod_step   = {acc_hi_step, mplier_step};
    end

`ifdef MUL_EARLY_OUT_EN
    logic [WIDTH-1:0] mrem;
    logic [WIDTH-1:0] mrem_step;
    logic [CNT_W-1:0] rem_shift;

    // mrem mirrors the multiplier bits not yet consumed; once it empties, the
    // remaining steps would only shift, so they collapse into one realignment.
    assign mrem_step  = mrem >> 1;
    assign early_done = (mrem_step == '0);
    assign rem_shift  = CNT_W'(WIDTH - 1) - cnt;
    assign prod_raw   = prod_step >> rem_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mrem <= '0;
        end else if (accept) begin
            mrem <= mag_b;
        end else if (state == ST_RUN && !flush_in) begin
            mrem <= mrem_step;
        end
    end
`else
    assign early_done = 1'b0;
    assign prod_raw   = prod_step;
`endif

    assign last_step = (cnt == CNT_W'(WIDTH - 1)) || early_done;
    assign prod_fin  = neg ? (~prod_raw + 1'b1) : prod_raw;
    assign ovf_fin   = sgn ? (prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}})
                           : (prod_fin[2*WIDTH-1:WIDTH] != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush_in)       state_nxt = ST_IDLE;
                else if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc_hi        <= '0;
            neg           <= 1'b0;
            sgn           <= 1'b0;
            result_lo_out <= '0;
            result_hi_out <= '0;
            ovf_out       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        neg    <= neg_in;
                        sgn    <= sign_in;
                    end
                end
                ST_RUN: begin
                    if (!flush_in) begin
                        acc_hi <= acc_hi_step;
                        mplier <= mplier_step;
                        cnt    <= cnt + 1'b1;
                        // Result registers load on the edge into DONE so they are valid with the pulse.
                        if (last_step) begin
                            result_lo_out <= prod_fin[WIDTH-1:0];
                            result_hi_out <= prod_fin[2*WIDTH-1:WIDTH];
                            ovf_out       <= ovf_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out     = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign stall_out    = accept | (state == ST_RUN);

endmodule
